// File: rtl/mmu_pkg.sv
// Shared MMU types: TLB entry layout, index type and the CP0 TLB operation codes.
package mmu_pkg;

   localparam int TLB_N_ENTRIES      = 32;
   localparam int TLB_IW             = $clog2(TLB_N_ENTRIES);
   localparam int TLB_PROBE_MISS_BIT = 31;

   typedef logic [TLB_IW-1:0] tlb_index_t;

   typedef struct packed {
      logic [15:0] page_mask;
      logic [18:0] vpn2;
      logic        g;
      logic [7:0]  asid;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   typedef enum logic [1:0] {
      TLB_OP_TLBR  = 2'd0,
      TLB_OP_TLBWI = 2'd1,
      TLB_OP_TLBWR = 2'd2,
      TLB_OP_TLBP  = 2'd3
   } tlb_op_t;

   function automatic logic tlb_op_writes(input tlb_op_t op);
      return (op == TLB_OP_TLBWI) || (op == TLB_OP_TLBWR);
   endfunction

endpackage

// File: rtl/tlb_random_reg.sv
// CP0 Random register: counts down from N-1 to Wired, then reloads N-1.
module tlb_random_reg
   import mmu_pkg::*;
#(
   parameter  int N_TLB_ENTRIES = 32,
   localparam int IW            = $clog2(N_TLB_ENTRIES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [IW-1:0] wired,
   input  logic          wired_we,
   output logic [IW-1:0] random
);

   localparam logic [IW-1:0] RAND_TOP = IW'(N_TLB_ENTRIES - 1);

   logic [IW-1:0] r_random;

   // Reaching Wired (or Wired >= N-1) reloads the top, so Random never drops below Wired.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_random <= RAND_TOP;
      end else if (wired_we || (r_random <= wired)) begin
         r_random <= RAND_TOP;
      end else begin
         r_random <= r_random - IW'(1);
      end
   end

   assign random = r_random;

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBR/TLBWI/TLBWR/TLBP: accept, drive the TLB ports for one cycle, respond.
module tlb_op_ctrl
   import mmu_pkg::*;
#(
   parameter  int N_TLB_ENTRIES = 32,
   localparam int IW            = $clog2(N_TLB_ENTRIES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  tlb_op_t       req_op,
   input  logic [31:0]   req_index,
   input  tlb_entry_t    req_entry,
   input  logic [31:0]   req_entry_hi,
   input  logic [IW-1:0] wired,
   input  logic          wired_we,
   output logic [IW-1:0] random,
   output logic          resp_valid,
   input  logic          resp_ready,
   output tlb_op_t       resp_op,
   output tlb_entry_t    resp_entry,
   output logic [31:0]   resp_index,
   output logic          flush,
   output logic [IW-1:0] tlbrw_index,
   output logic          tlbrw_we,
   output tlb_entry_t    tlbrw_wrdata,
   input  tlb_entry_t    tlbrw_rddata,
   output logic [31:0]   tlbp_entry_hi,
   input  logic [31:0]   tlbp_index
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   tlb_op_t       r_op;
   logic [IW-1:0] r_index;
   logic [IW-1:0] r_rand;
   tlb_entry_t    r_entry;
   logic [31:0]   r_key;
   tlb_entry_t    r_resp_entry;
   logic [31:0]   r_resp_index;
   logic          r_flush;
   logic          w_accept;

   // CP0 Index is architecturally wider than the TLB; the upper bits are ignored.
   logic [31-IW:0] w_unused_index_hi;
   assign w_unused_index_hi = req_index[31:IW];

   tlb_random_reg #(
      .N_TLB_ENTRIES (N_TLB_ENTRIES)
   ) u_random (
      .clk      (clk),
      .rst      (rst),
      .wired    (wired),
      .wired_we (wired_we),
      .random   (random)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      tlbrw_we      = 1'b0;
      tlbrw_index   = '0;
      tlbrw_wrdata  = '0;
      tlbp_entry_hi = '0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            tlbrw_we      = tlb_op_writes(r_op);
            tlbrw_index   = (r_op == TLB_OP_TLBWR) ? r_rand : r_index;
            tlbrw_wrdata  = r_entry;
            tlbp_entry_hi = r_key;
            w_state_next  = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign w_accept = (r_state == ST_IDLE) && req_valid;

   // Random is snapshotted at accept so a TLBWR targets the value seen when it issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op         <= TLB_OP_TLBR;
         r_index      <= '0;
         r_rand       <= '0;
         r_entry      <= '0;
         r_key        <= '0;
         r_resp_entry <= '0;
         r_resp_index <= '0;
         r_flush      <= 1'b0;
      end else begin
         r_flush <= 1'b0;
         if (w_accept) begin
            r_op    <= req_op;
            r_index <= req_index[IW-1:0];
            r_rand  <= random;
            r_entry <= req_entry;
            r_key   <= req_entry_hi;
         end
         if (r_state == ST_EXEC) begin
            r_resp_entry <= (r_op == TLB_OP_TLBR) ? tlbrw_rddata : '0;
            r_resp_index <= (r_op == TLB_OP_TLBP) ? tlbp_index : '0;
            r_flush      <= tlb_op_writes(r_op);
         end
      end
   end

   assign resp_op    = r_op;
   assign resp_entry = r_resp_entry;
   assign resp_index = r_resp_index;
   assign flush      = r_flush;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a behavioural TLB stub and a response scoreboard.
module tb_tlb_op_ctrl;
   import mmu_pkg::*;

   localparam int N  = 32;
   localparam int IW = $clog2(N);

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   tlb_op_t       req_op;
   logic [31:0]   req_index;
   tlb_entry_t    req_entry;
   logic [31:0]   req_entry_hi;
   logic [IW-1:0] wired;
   logic          wired_we;
   logic [IW-1:0] random;
   logic          resp_valid;
   logic          resp_ready;
   tlb_op_t       resp_op;
   tlb_entry_t    resp_entry;
   logic [31:0]   resp_index;
   logic          flush;
   logic [IW-1:0] tlbrw_index;
   logic          tlbrw_we;
   tlb_entry_t    tlbrw_wrdata;
   tlb_entry_t    tlbrw_rddata;
   logic [31:0]   tlbp_entry_hi;
   logic [31:0]   tlbp_index;

   tlb_op_ctrl #(.N_TLB_ENTRIES(N)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_index     (req_index),
      .req_entry     (req_entry),
      .req_entry_hi  (req_entry_hi),
      .wired         (wired),
      .wired_we      (wired_we),
      .random        (random),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_op       (resp_op),
      .resp_entry    (resp_entry),
      .resp_index    (resp_index),
      .flush         (flush),
      .tlbrw_index   (tlbrw_index),
      .tlbrw_we      (tlbrw_we),
      .tlbrw_wrdata  (tlbrw_wrdata),
      .tlbrw_rddata  (tlbrw_rddata),
      .tlbp_entry_hi (tlbp_entry_hi),
      .tlbp_index    (tlbp_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      tlb_op_t     op;
      tlb_entry_t  entry;
      logic [31:0] index;
      logic        flush;
   } exp_t;

   exp_t sb_q[$];

   function automatic tlb_entry_t mk_entry(input int i);
      tlb_entry_t e;
      e      = '0;
      e.vpn2 = 19'(32'h100 + i);
      e.asid = 8'(i);
      e.pfn0 = 20'(32'hA0000 + i);
      e.pfn1 = 20'(32'hB0000 + i);
      e.c0   = 3'd3;
      e.v0   = 1'b1;
      e.d1   = 1'b1;
      return e;
   endfunction

   // TLB stub: reset with the same rst, synchronous write, combinational read and probe.
   tlb_entry_t tb_mem [N];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) tb_mem[i] <= mk_entry(i);
      end else if (tlbrw_we) begin
         tb_mem[tlbrw_index] <= tlbrw_wrdata;
      end
   end
   assign tlbrw_rddata = tb_mem[tlbrw_index];
   always_comb begin
      tlbp_index = 32'h8000_0000;
      for (int i = N - 1; i >= 0; i--) begin
         if (tb_mem[i].vpn2 == tlbp_entry_hi[31:13]) tlbp_index = 32'(i);
      end
   end

   // Reference Random, used to steer stimulus timing and check counting during operations.
   logic [IW-1:0] m_rand;
   always @(posedge clk) begin
      if (rst || wired_we || (m_rand <= wired)) m_rand <= IW'(N - 1);
      else m_rand <= m_rand - IW'(1);
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_rand(input logic [IW-1:0] target);
      int n = 0;
      while (m_rand != target && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("wait_rand_bound", 128'(n < 40), 128'(1));
   endtask

   task automatic run_op(input tlb_op_t op, input logic [31:0] idx, input tlb_entry_t e,
                         input logic [31:0] key, input logic [IW-1:0] exp_row,
                         input tlb_entry_t exp_entry, input logic [31:0] exp_index,
                         input int hold, input logic pulse_wired);
      exp_t x;
      exp_t got;
      int   n;
      logic wr;
      wr       = (op == TLB_OP_TLBWI) || (op == TLB_OP_TLBWR);
      x.op     = op;
      x.entry  = exp_entry;
      x.index  = exp_index;
      x.flush  = wr;
      sb_q.push_back(x);
      chk("idle_req_ready", req_ready, 1);
      req_valid    = 1'b1;
      req_op       = op;
      req_index    = idx;
      req_entry    = e;
      req_entry_hi = key;
      wired_we     = pulse_wired;
      @(negedge clk);
      req_valid = 1'b0;
      wired_we  = 1'b0;
      chk("exec_we", tlbrw_we, wr);
      chk("exec_index", tlbrw_index, exp_row);
      chk("exec_wrdata", tlbrw_wrdata, e);
      chk("exec_key", tlbp_entry_hi, key);
      chk("exec_req_ready", req_ready, 0);
      chk("exec_resp_valid", resp_valid, 0);
      if (pulse_wired) chk("random_after_we", random, 31);
      else chk("random_running", random, m_rand);
      @(negedge clk);
      n = 0;
      while (!resp_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("resp_latency", n, 0);
      chk("resp_valid", resp_valid, 1);
      got = sb_q.pop_front();
      chk("resp_op", resp_op, got.op);
      chk("resp_entry", resp_entry, got.entry);
      chk("resp_index", resp_index, got.index);
      chk("flush_first", flush, got.flush);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", resp_valid, 1);
         chk("hold_index", resp_index, got.index);
         chk("hold_entry", resp_entry, got.entry);
         chk("hold_req_ready", req_ready, 0);
         chk("hold_flush", flush, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("done_resp_valid", resp_valid, 0);
      chk("done_req_ready", req_ready, 1);
      chk("done_flush", flush, 0);
      chk("done_we", tlbrw_we, 0);
      chk("done_rw_index", tlbrw_index, 0);
      chk("done_key", tlbp_entry_hi, 0);
      $display("op=%0d idx=%0d row=%0d resp_index=%0h flush_exp=%0b", op, idx, exp_row, exp_index, wr);
   endtask

   tlb_entry_t e1, e2, e3;

   initial begin
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_op       = TLB_OP_TLBR;
      req_index    = '0;
      req_entry    = '0;
      req_entry_hi = '0;
      wired        = '0;
      wired_we     = 1'b0;
      resp_ready   = 1'b0;
      e1 = '0; e1.vpn2 = 19'h5A5A5; e1.pfn0 = 20'h12345; e1.v0 = 1'b1; e1.asid = 8'h77;
      e2 = '0; e2.vpn2 = 19'h12345; e2.pfn1 = 20'hFEDCB; e2.g = 1'b1; e2.page_mask = 16'h0003;
      e3 = '0; e3.vpn2 = 19'h0ABCD; e3.c1 = 3'd5;
      repeat (2) @(negedge clk);

      chk("rst_random", random, 31);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_flush", flush, 0);
      chk("rst_we", tlbrw_we, 0);
      chk("rst_resp_index", resp_index, 0);
      chk("rst_resp_entry", resp_entry, 0);
      rst = 1'b0;

      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         chk("random_seq", random, (i == 32) ? 31 : 31 - i);
      end

      run_op(TLB_OP_TLBWI, 32'd5, e1, 32'h0, 5'd5, '0, 32'h0, 1, 1'b0);
      wait_rand(5'd17);
      run_op(TLB_OP_TLBWR, 32'd0, e2, 32'h0, 5'd17, '0, 32'h0, 0, 1'b0);
      run_op(TLB_OP_TLBR, 32'd5, e3, 32'h0, 5'd5, e1, 32'h0, 0, 1'b0);
      run_op(TLB_OP_TLBR, 32'd17, e3, 32'h0, 5'd17, e2, 32'h0, 0, 1'b0);
      run_op(TLB_OP_TLBP, 32'd0, e3, {19'h103, 13'h0}, 5'd0, '0, 32'd3, 0, 1'b0);
      run_op(TLB_OP_TLBP, 32'd0, e3, 32'hFFFF_E000, 5'd0, '0, 32'h8000_0000, 4, 1'b0);
      run_op(TLB_OP_TLBR, 32'd33, e3, 32'h0, 5'd1, mk_entry(1), 32'h0, 0, 1'b0);

      wired    = 5'd8;
      wired_we = 1'b1;
      @(negedge clk);
      wired_we = 1'b0;
      chk("wired_reload", random, 31);
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         chk("random_wired_seq", random, (i == 24) ? 31 : 31 - i);
      end

      wait_rand(5'd20);
      run_op(TLB_OP_TLBWR, 32'd0, e3, 32'h0, 5'd20, '0, 32'h0, 0, 1'b1);

      // Reset while a TLBWI response is pending.
      req_valid = 1'b1;
      req_op    = TLB_OP_TLBWI;
      req_index = 32'd9;
      req_entry = e2;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstop_exec_we", tlbrw_we, 1);
      @(negedge clk);
      chk("rstop_resp_valid", resp_valid, 1);
      chk("rstop_flush", flush, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstop_after_valid", resp_valid, 0);
      chk("rstop_after_ready", req_ready, 1);
      chk("rstop_after_flush", flush, 0);
      chk("rstop_after_random", random, 31);
      $display("op=%0d idx=9 reset during RESP", TLB_OP_TLBWI);

      run_op(TLB_OP_TLBR, 32'd9, e3, 32'h0, 5'd9, mk_entry(9), 32'h0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for CP0 TLB instructions (TLBR, TLBWI, TLBWR, TLBP). It sits between the CP0/execute stage and the MMU's TLB maintenance ports (`tlbrw_*`, `tlbp_*`). It accepts one operation at a time over a valid/ready handshake, drives the TLB ports for exactly one cycle, and returns results over a valid/ready response. It also owns the CP0 Random register and signals a pipeline flush after any TLB write.

## Interface
- `N_TLB_ENTRIES`, default 32: TLB depth; index width `IW = $clog2(N_TLB_ENTRIES)`.
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: operation request.
- `req_ready` output 1: high only in IDLE.
- `req_op` input 2: `tlb_op_t` (TLBR=0, TLBWI=1, TLBWR=2, TLBP=3).
- `req_index` input 32: CP0 Index; only bits `[IW-1:0]` are used.
- `req_entry` input `tlb_entry_t`: write data built from EntryHi/Lo0/Lo1/PageMask.
- `req_entry_hi` input 32: probe key for TLBP.
- `wired` input `IW`: CP0 Wired value.
- `wired_we` input 1: CP0 write to Wired this cycle.
- `random` output `IW`: CP0 Random value.
- `resp_valid` output 1: result available.
- `resp_ready` input 1: consumer accepts the result.
- `resp_op` output 2: op being answered.
- `resp_entry` output `tlb_entry_t`: TLBR read data; 0 for other ops.
- `resp_index` output 32: TLBP result (bit31 = probe miss); 0 for other ops.
- `flush` output 1: one-cycle pulse after TLBWI/TLBWR.
- `tlbrw_index` output `IW`: TLB row address.
- `tlbrw_we` output 1: TLB write strobe.
- `tlbrw_wrdata` output `tlb_entry_t`: TLB write data.
- `tlbrw_rddata` input `tlb_entry_t`: combinational TLB read data.
- `tlbp_entry_hi` output 32: probe key.
- `tlbp_index` input 32: combinational probe result.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `req_ready=1`. On `req_valid`, latch op, `req_index[IW-1:0]`, `req_entry`, `req_entry_hi`, and the current `random` (TLBWR target), then go to EXEC.
- EXEC (always exactly one cycle):
  - `tlbrw_index` = latched Random for TLBWR, latched Index otherwise.
  - `tlbrw_we=1` only for TLBWI/TLBWR.
  - `tlbrw_wrdata` = latched entry.
  - `tlbp_entry_hi` = latched key.
  - At the clock edge, capture `tlbrw_rddata` into `resp_entry` (TLBR only) and `tlbp_index` into `resp_index` (TLBP only).
  - Go to RESP.
- RESP: `resp_valid=1`, outputs held stable until `resp_valid && resp_ready`, then return to IDLE. A new request is not accepted in the same cycle.
- `flush` is high in the first RESP cycle of TLBWI/TLBWR only.
- Random:
  - Reset value N-1.
  - Each cycle: if `wired_we`, load N-1; else if `random <= wired`, load N-1; else decrement by 1.
  - If `wired >= N-1`, Random is held at N-1.
  - Random counts in every state, including during an operation.
- Outside EXEC, `tlbrw_we=0`. `tlbrw_index`, `tlbrw_wrdata` and `tlbp_entry_hi` are 0 outside EXEC.

## Timing
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `flush=0`, `tlbrw_we=0`, `resp_*=0`, `random=N-1`.
- Latency: accept at edge t; EXEC during cycle t+1; `resp_valid` rises in cycle t+2. Minimum of 3 cycles per operation, then one further IDLE cycle before the next accept.
- `rst` asserted in any state returns the FSM to IDLE at the next edge and discards any pending response. If `rst` is asserted during EXEC, the `tlbrw_we` strobe still appears in that cycle; the TLB itself is reset by the same `rst`.
- `wired_we` coincident with the TLBWR accept: the latched Random is the pre-update value.
- Random wrap: the value sequence is N-1 … wired, then N-1 again. It never goes below `wired`.

## Structure
- `tlb_op_t` and `TLB_PROBE_MISS_BIT=31` are added to the shared mmu package next to `tlb_entry_t` and `tlb_index_t`.
- The Random counter is a natural sub-module: `tlb_random_reg` (inputs `clk`, `rst`, `wired`, `wired_we`; output `random`).
- The FSM and result registers live in `tlb_op_ctrl`.

## Test plan
- After reset, with `wired=0` and N=32: `random` reads 31, 30, … 0, 31 on consecutive cycles. `req_ready=1`, `resp_valid=0`.
- TLBWI with `req_index=5` and entry E: `tlbrw_we=1` and `tlbrw_index=5` for exactly one cycle (t+1). `flush` pulses at t+2. `resp_valid` rises at t+2.
- TLBWR accepted while `random=17`: write goes to index 17. `wired=8, wired_we` for one cycle: `random` becomes 31, then counts down to 8 and wraps to 31.
- TLBP with key hitting entry 3 returns `resp_index=3`. TLBP with a missing key returns bit31=1. `resp_ready` is held low for 4 cycles: `resp_*` stay stable and `req_ready` stays 0.
- TLBR at `req_index=33` (N=32) reads row 1 (masked). `rst` asserted during RESP: `resp_valid=0` and `req_ready=1` on the next cycle, with no `flush`.
